// File: rtl/wire_test_pkg.sv
// wire_test_pkg: shared state encoding, defaults and a sizing helper for the wire test sequencer
package wire_test_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
  localparam int HOLD_CYCLES_DEF = 20;
  localparam int NUM_STEPS_DEF = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wire_test_seq_if.sv
// wire_test_seq_if: stimulus/observation bus between a test controller and the wire test sequencer
interface wire_test_seq_if import wire_test_pkg::*; #(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int CNT_W = 8
);
  localparam int SW = idx_w(NUM_STEPS);
  logic start;
  logic [NUM_STEPS-1:0] pattern;
  logic stim;
  logic obs_b;
  logic obs_c;
  logic busy;
  logic done;
  logic pass;
  logic [CNT_W-1:0] err_count;
  logic [SW-1:0] step_idx;
  modport master(output start, pattern, obs_b, obs_c, input stim, busy, done, pass, err_count, step_idx);
  modport slave(input start, pattern, obs_b, obs_c, output stim, busy, done, pass, err_count, step_idx);
endinterface

// File: rtl/wire_test_seq_hold_timer.sv
// hold_timer: modulo-HOLD_CYCLES counter with clear and a last-cycle flag
module hold_timer import wire_test_pkg::*; #(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int W = idx_w(HOLD_CYCLES);
  logic [W-1:0] cnt;
  assign last = cnt == W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? (last ? '0 : cnt + 1'b1) : cnt;
endmodule

// File: rtl/wire_test_seq.sv
// wire_test_seq: drives a wire-under-test with a held bit pattern and counts per-step output mismatches
// Optional WIRE_TEST_INV_C_EN: output C is expected to be the inverse of the stimulus.
module wire_test_seq import wire_test_pkg::*; #(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  wire_test_seq_if.slave bus
);
  localparam int SW = idx_w(NUM_STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
  state_t state, nxt;
  logic [NUM_STEPS-1:0] pat_q;
  logic [SW-1:0] step;
  logic [CNT_W-1:0] err;
  logic pass_q, last, exp_c, miss;
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != DRIVE),
    .en(state == DRIVE),
    .last(last)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (bus.start ? DRIVE : IDLE) :
          state == DRIVE ? ((last && step == LAST_STEP) ? DONE : DRIVE) : IDLE;
  always_comb begin
    bus.stim = state == DRIVE && pat_q[step];
    bus.busy = state == DRIVE;
    bus.done = state == DONE;
  end
`ifdef WIRE_TEST_INV_C_EN
  assign exp_c = ~bus.stim;
`else
  assign exp_c = bus.stim;
`endif
  assign miss = (bus.obs_b != bus.stim) || (bus.obs_c != exp_c);
  // the step's final hold cycle samples the outputs and advances; the error from the last step lands before DONE
  always_ff @(posedge clk)
    if (rst) begin
      pat_q <= '0;
      step <= '0;
      err <= '0;
      pass_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      pat_q <= bus.pattern;
      step <= '0;
      err <= '0;
      pass_q <= 1'b0;
    end else if (state == DRIVE && last) begin
      if (miss && err != '1) err <= err + 1'b1;
      if (step != LAST_STEP) step <= step + 1'b1;
    end else if (state == DONE) begin
      pass_q <= err == '0;
    end
  assign bus.err_count = err;
  assign bus.pass = pass_q;
  assign bus.step_idx = step;
endmodule

// File: tb/tb_wire_test_seq.sv
// tb_wire_test_seq: randomized self-checking bench for wire_test_seq against a per-step reference model
module tb_wire_test_seq;
  import wire_test_pkg::*;
  localparam int H = 20;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int bm1 = 0, cm1 = 0, bm2 = 0, cm2 = 0;
  wire_test_seq_if #(.NUM_STEPS(N), .CNT_W(8)) bus1();
  wire_test_seq_if #(.NUM_STEPS(N), .CNT_W(1)) bus2();
  wire_test_seq #(.HOLD_CYCLES(H), .NUM_STEPS(N), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  wire_test_seq #(.HOLD_CYCLES(1), .NUM_STEPS(N), .CNT_W(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  always #5 clk = ~clk;
  // wire behaviour: 0 follows, 1 stuck low, 2 stuck high, 3 inverts
  function automatic logic wire_out(input int m, input logic s);
    return m == 0 ? s : m == 1 ? 1'b0 : m == 2 ? 1'b1 : ~s;
  endfunction
  function automatic logic want_c(input logic s);
`ifdef WIRE_TEST_INV_C_EN
    return ~s;
`else
    return s;
`endif
  endfunction
  function automatic int model_err(input logic [N-1:0] pat, input int bm, input int cm, input int cmax);
    int e = 0;
    for (int i = 0; i < N; i++)
      if (wire_out(bm, pat[i]) !== pat[i] || wire_out(cm, pat[i]) !== want_c(pat[i])) e++;
    return e > cmax ? cmax : e;
  endfunction
  always_comb begin
    bus1.obs_b = wire_out(bm1, bus1.stim);
    bus1.obs_c = wire_out(cm1, bus1.stim);
    bus2.obs_b = wire_out(bm2, bus2.stim);
    bus2.obs_c = wire_out(cm2, bus2.stim);
  end
  task automatic run1(input logic [N-1:0] pat, input int bm, input int cm, input bit spam);
    int e;
    e = model_err(pat, bm, cm, 255);
    @(negedge clk);
    bus1.pattern = pat;
    bus1.start = 1'b1;
    bm1 = bm;
    cm1 = cm;
    @(negedge clk);
    bus1.start = spam;
    for (int t = 0; t < N * H; t++) begin
      n_cmp++;
      if (bus1.busy !== 1'b1 || bus1.done !== 1'b0 || bus1.stim !== pat[t/H] || bus1.step_idx !== 2'(t / H)) begin
        n_bad++;
        $display("FAIL run1_drive t=%0d pat=%b: busy=%b done=%b stim=%b step=%0d, want busy=1 done=0 stim=%b step=%0d",
                 t, pat, bus1.busy, bus1.done, bus1.stim, bus1.step_idx, pat[t/H], t / H);
      end
      @(negedge clk);
    end
    bus1.start = 1'b0;
    n_cmp++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.stim !== 1'b0) begin
      n_bad++;
      $display("FAIL run1_done pat=%b: done=%b busy=%b stim=%b, want 1 0 0", pat, bus1.done, bus1.busy, bus1.stim);
    end
    n_cmp++;
    if (bus1.err_count !== 8'(e)) begin
      n_bad++;
      $display("FAIL run1_err pat=%b bm=%0d cm=%0d: err_count=%0d, want %0d", pat, bm, cm, bus1.err_count, e);
    end
    @(negedge clk);
    n_cmp++;
    if (bus1.done !== 1'b0 || bus1.pass !== (e == 0)) begin
      n_bad++;
      $display("FAIL run1_pass pat=%b: done=%b pass=%b, want done=0 pass=%b", pat, bus1.done, bus1.pass, e == 0);
    end
  endtask
  task automatic run2(input logic [N-1:0] pat, input int bm, input int cm);
    int e;
    e = model_err(pat, bm, cm, 1);
    @(negedge clk);
    bus2.pattern = pat;
    bus2.start = 1'b1;
    bm2 = bm;
    cm2 = cm;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int t = 0; t < N; t++) begin
      n_cmp++;
      if (bus2.busy !== 1'b1 || bus2.done !== 1'b0 || bus2.stim !== pat[t]) begin
        n_bad++;
        $display("FAIL run2_drive t=%0d pat=%b: busy=%b done=%b stim=%b, want 1 0 %b", t, pat, bus2.busy, bus2.done, bus2.stim, pat[t]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus2.done !== 1'b1 || bus2.err_count !== 1'(e)) begin
      n_bad++;
      $display("FAIL run2_done pat=%b bm=%0d cm=%0d: done=%b err=%0d, want done=1 err=%0d", pat, bm, cm, bus2.done, bus2.err_count, e);
    end
    @(negedge clk);
    n_cmp++;
    if (bus2.done !== 1'b0 || bus2.pass !== (e == 0)) begin
      n_bad++;
      $display("FAIL run2_pass pat=%b: done=%b pass=%b, want done=0 pass=%b", pat, bus2.done, bus2.pass, e == 0);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus1.stim, bus1.busy, bus1.done, bus1.pass} !== 4'b0 || bus1.err_count !== 8'd0 || bus1.step_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_dut1: stim=%b busy=%b done=%b pass=%b err=%0d step=%0d, want all 0",
               bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.step_idx);
    end
    n_cmp++;
    if ({bus2.stim, bus2.busy, bus2.done, bus2.pass, bus2.err_count} !== 5'b0 || bus2.step_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_dut2: stim=%b busy=%b done=%b pass=%b err=%0d, want all 0",
               bus2.stim, bus2.busy, bus2.done, bus2.pass, bus2.err_count);
    end
    rst = 1'b0;
  endtask
  task automatic test_mid_reset();
    bit seen_done = 0;
    @(negedge clk);
    bus1.pattern = 4'b1010;
    bus1.start = 1'b1;
    bm1 = 0;
    cm1 = 1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (2 * H + 5) @(negedge clk);
    n_cmp++;
    if (bus1.err_count !== 8'd1 || bus1.step_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_pre: err=%0d step=%0d, want err=1 step=2", bus1.err_count, bus1.step_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus1.stim, bus1.busy, bus1.done, bus1.pass} !== 4'b0 || bus1.err_count !== 8'd0 || bus1.step_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset: stim=%b busy=%b done=%b pass=%b err=%0d step=%0d, want all 0",
               bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.step_idx);
    end
    for (int t = 0; t < N * H + 5; t++) begin
      if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) seen_done = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL mid_quiet: done/busy went high after reset, want both 0");
    end
    run1(4'b0110, 0, 0, 0);
  endtask
  initial begin
    bus1.start = 1'b0;
    bus1.pattern = '0;
    bus2.start = 1'b0;
    bus2.pattern = '0;
    test_reset();
    run1(4'b1010, 0, 0, 0);
    run1(4'b1010, 0, 1, 0);
    test_mid_reset();
    run1(4'b1101, 0, 0, 1);
    run1(4'($urandom), 0, 3, 0);
    run2(4'b0000, 2, 0);
    run2(4'b1111, 0, 0);
    for (int i = 0; i < 8; i++) run1(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    for (int i = 0; i < 8; i++) run2(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wire_test_seq.md
# wire_test_seq

Clocked sequencer that drives a wire-under-test with a programmable stimulus pattern and checks its outputs. It replaces hand-timed `#delay` stimulus with a synthesizable controller: one bit is applied per step, held for a fixed number of cycles, the observed outputs are compared at the end of each hold, mismatches are counted, and a pass/fail verdict is reported. It sits between lab test benches or board-level test logic and any 1-in/2-out wire block whose outputs both follow its input.

## Interface
- HOLD_CYCLES, 20, cycles each stimulus bit is held; must be ≥1
- NUM_STEPS, 4, number of stimulus steps per run
- CNT_W, 8, width of the error counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- pattern  in  NUM_STEPS  stimulus bits; bit i is applied at step i; latched at start
- stim  out  1  drives the wire-under-test input (A)
- obs_b  in  1  observed output B
- obs_c  in  1  observed output C
- busy  out  1  high while a run is in progress (DRIVE state)
- done  out  1  one-cycle pulse when a run ends
- pass  out  1  result of the last run: 1 if err_count==0; held until the next start
- err_count  out  CNT_W  number of steps with any mismatch; saturating
- step_idx  out  clog2(NUM_STEPS) or 1  index of the current step

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: stim=0, busy=0. On start=1, latch pattern, clear err_count, pass, step_idx and the hold counter, then go to DRIVE.
- DRIVE: stim=pattern_q[step_idx]; the hold counter runs 0..HOLD_CYCLES-1.
  - On the final hold cycle, sample obs_b and obs_c. Expected values: B=stim and C=stim.
  - If either mismatches, err_count+1, saturating at 2^CNT_W-1. Count at most one error per step.
  - If step_idx==NUM_STEPS-1, go to DONE. Otherwise step_idx+1 and clear the hold counter.
- DONE: done=1 for exactly one cycle; pass<=(err_count==0), including any error from the final step; stim=0; next state is IDLE.
- start in DRIVE or DONE: ignored, no effect.
- Reset (any state, including mid-run): next cycle is IDLE and all outputs take their reset values.
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, step_idx=0.

## Timing
- start high at edge k (in IDLE): busy=1 and stim=pattern[0] are visible after edge k.
- Step i occupies cycles k+1+i·HOLD_CYCLES through k+(i+1)·HOLD_CYCLES.
- Sampling happens at the edge ending the last cycle of each step. Outputs under test must be settled within HOLD_CYCLES-1 cycles.
- done is high in cycle k+1+NUM_STEPS·HOLD_CYCLES; busy is low in that cycle.
- A new start is accepted from the cycle after done.
- HOLD_CYCLES=1: sample in the same cycle the bit is applied; a purely combinational wire must still pass.
- Total run latency, start to done: NUM_STEPS·HOLD_CYCLES+1 cycles.

## Configuration
- WIRE_TEST_INV_C_EN defined: the expected value of C is ~stim, for inverter-on-C variants. B is still expected to equal stim.
- WIRE_TEST_INV_C_EN undefined: C is expected to equal stim.
- No port changes in either case.

## Structure
- Shared package wire_test_pkg holds:
  - state encoding constants: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2
  - the default HOLD_CYCLES and NUM_STEPS values
- One sub-module, hold_timer: a HOLD_CYCLES modulo counter with clear and a last-cycle flag. It is reused by other lab sequencers.
- The FSM, step index, pattern register and checker stay in wire_test_seq.

## Test plan
- Loopback (obs_b=obs_c=stim), defaults, pattern=4'b1010 → stim sequence 0,1,0,1 at 20 cycles each; done 81 cycles after start; pass=1, err_count=0.
- obs_c stuck at 0, pattern=4'b1010 → steps 1 and 3 mismatch; err_count=2, pass=0.
- rst pulsed during step 2 → IDLE next cycle; stim=0, busy=0, err_count=0, no done pulse; a new start runs cleanly.
- start re-asserted on every cycle of a run → ignored; exactly one done pulse; step timing unchanged.
- WIRE_TEST_INV_C_EN defined, obs_c=~stim, obs_b=stim → pass=1; the same bench without the macro gives err_count=4.
- CNT_W=1, HOLD_CYCLES=1, obs_b stuck at 1, pattern=4'b0000 → err_count saturates at 1; done 5 cycles after start; pass=0.
